// File: rtl/shifter_right_seq_if.sv
// Request/response bundle for the sequential right shifter.
// master drives the request, slave (the shifter) returns the status and result.
interface shifter_right_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
);
  logic             start;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   amount;
  logic             arith;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, operand, amount, arith,
    input  busy, done, result
  );

  modport slave (
    input  start, operand, amount, arith,
    output busy, done, result
  );
endinterface

// File: rtl/shifter_right_seq.sv
// Multi-cycle right shifter: one bit per clock, logical or arithmetic fill.
// Result and a one-cycle done pulse appear amount+1 cycles after the accepting edge.
module shifter_right_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input logic              clk,
  input logic              rst_n,
  shifter_right_seq_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [SHW-1:0]   cnt;
  logic             fill;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  // Data ports are sampled only on the accepting edge; done is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      fill     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr     <= bus.operand;
            cnt    <= bus.amount;
            fill   <= bus.arith & bus.operand[WIDTH-1];
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sr  <= {fill, sr[WIDTH-1:1]};
            cnt <= cnt - SHW'(1);
          end else begin
            result_q <= sr;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
